// File: rtl/pr_hrav_pkg.sv
// Shared constants for the hardware-RAV collector arbiter: grant encodings, source indices, width helpers.
// No logic and no latency.
// No flow control lives here.
package pr_hrav_pkg;

    // Values driven on grant_state
    localparam logic [1:0] GS_IDLE  = 2'd0;
    localparam logic [1:0] GS_ICAP  = 2'd1;
    localparam logic [1:0] GS_CORE0 = 2'd2;
    localparam logic [1:0] GS_CORE1 = 2'd3;

    // Bit positions of each source in per-source vectors
    localparam int SRC_ICAP  = 0;
    localparam int SRC_CORE0 = 1;
    localparam int SRC_CORE1 = 2;
    localparam int NUM_SRC   = 3;

    // FSM encoding matches grant_state, so the state register drives that port directly
    typedef enum logic [1:0] {
        ST_IDLE      = GS_IDLE,
        ST_GNT_ICAP  = GS_ICAP,
        ST_GNT_CORE0 = GS_CORE0,
        ST_GNT_CORE1 = GS_CORE1
    } gnt_state_t;

    // One TSTRB bit per TDATA byte
    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    // Master and slave data paths must match and be byte-granular
    function automatic bit widths_ok(input int m_width, input int s_width);
        return (m_width == s_width) && ((s_width % 8) == 0);
    endfunction

endpackage

// File: rtl/pr_hrav_axis_reg_slice.sv
// One-beat registered AXI4-Stream output stage feeding the collector master port.
// Latency: a beat loaded at edge n is presented from n+1.
// Backpressure: space = !valid | ready, so a stalled full register refuses new beats the same cycle.
module pr_hrav_axis_reg_slice
    import pr_hrav_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic [DATA_WIDTH-1:0]             load_data,
    input  logic [strb_width(DATA_WIDTH)-1:0] load_strb,
    input  logic [USER_WIDTH-1:0]             load_user,
    input  logic                              load_last,
    output logic                              space,
    output logic [DATA_WIDTH-1:0]             data,
    output logic [strb_width(DATA_WIDTH)-1:0] strb,
    output logic [USER_WIDTH-1:0]             user,
    output logic                              last,
    output logic                              valid,
    input  logic                              ready
);

    // The register can take a beat when empty or when its current beat leaves this cycle
    assign space = !valid || ready;

    // Load a new beat, otherwise drain once downstream takes it; payload holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            strb  <= '0;
            user  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            strb  <= load_strb;
            user  <= load_user;
            last  <= load_last;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pr_hrav_collector_arbiter.sv
// Packet-granular merge of ICAP (strict priority) and CORE0/CORE1 (round-robin) onto one master stream.
// Latency: 1 cycle arbitration from IDLE, then 1 cycle source-to-master through the output register.
// Backpressure: granted TREADY follows the output register's space; ungranted sources see TREADY=0.
module pr_hrav_collector_arbiter
    import pr_hrav_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH = 256,
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int C_USER_WIDTH        = 128
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic                               core_0_enb,
    input  logic                               core_1_enb,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic [C_USER_WIDTH-1:0]            M_AXIS_TUSER,
    output logic                               M_AXIS_TLAST,
    output logic                               M_AXIS_TVALID,
    input  logic                               M_AXIS_TREADY,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     CORE0_S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   CORE0_S_AXIS_TSTRB,
    input  logic [C_USER_WIDTH-1:0]            CORE0_S_AXIS_TUSER,
    input  logic                               CORE0_S_AXIS_TLAST,
    input  logic                               CORE0_S_AXIS_TVALID,
    output logic                               CORE0_S_AXIS_TREADY,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     CORE1_S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   CORE1_S_AXIS_TSTRB,
    input  logic [C_USER_WIDTH-1:0]            CORE1_S_AXIS_TUSER,
    input  logic                               CORE1_S_AXIS_TLAST,
    input  logic                               CORE1_S_AXIS_TVALID,
    output logic                               CORE1_S_AXIS_TREADY,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     ICAP_S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   ICAP_S_AXIS_TSTRB,
    input  logic [C_USER_WIDTH-1:0]            ICAP_S_AXIS_TUSER,
    input  logic                               ICAP_S_AXIS_TLAST,
    input  logic                               ICAP_S_AXIS_TVALID,
    output logic                               ICAP_S_AXIS_TREADY,
    output logic [1:0]                         grant_state,
    output logic [31:0]                        pkt_cnt_core0,
    output logic [31:0]                        pkt_cnt_core1,
    output logic [31:0]                        pkt_cnt_icap
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int SW = strb_width(C_S_AXIS_DATA_WIDTH);

    if (!widths_ok(C_M_AXIS_DATA_WIDTH, C_S_AXIS_DATA_WIDTH)) begin : g_width_check
        $error("pr_hrav_collector_arbiter: master/slave TDATA widths must match and be byte multiples");
    end

    gnt_state_t           state;
    logic                 last_core;     // 0: CORE0 was granted last, 1: CORE1 (or none since reset)
    logic [31:0]          cnt_icap;
    logic [31:0]          cnt_core0;
    logic [31:0]          cnt_core1;

    logic                 slice_space;
    logic                 mux_valid;
    logic [DW-1:0]        mux_data;
    logic [SW-1:0]        mux_strb;
    logic [C_USER_WIDTH-1:0] mux_user;
    logic                 mux_last;
    logic [NUM_SRC-1:0]   rdy_vec;
    logic                 beat_accept;
    logic                 req_icap;
    logic                 req_core0;
    logic                 req_core1;

    // Requests eligible for a new grant; enables only gate arbitration, never an open packet
    assign req_icap  = ICAP_S_AXIS_TVALID;
    assign req_core0 = CORE0_S_AXIS_TVALID && core_0_enb;
    assign req_core1 = CORE1_S_AXIS_TVALID && core_1_enb;

    // Route the granted source to the output register and hand it the register's space as TREADY
    always_comb begin
        mux_valid = 1'b0;
        mux_data  = '0;
        mux_strb  = '0;
        mux_user  = '0;
        mux_last  = 1'b0;
        rdy_vec   = '0;
        case (state)
            ST_GNT_ICAP: begin
                mux_valid          = ICAP_S_AXIS_TVALID;
                mux_data           = ICAP_S_AXIS_TDATA;
                mux_strb           = ICAP_S_AXIS_TSTRB;
                mux_user           = ICAP_S_AXIS_TUSER;
                mux_last           = ICAP_S_AXIS_TLAST;
                rdy_vec[SRC_ICAP]  = slice_space;
            end
            ST_GNT_CORE0: begin
                mux_valid          = CORE0_S_AXIS_TVALID;
                mux_data           = CORE0_S_AXIS_TDATA;
                mux_strb           = CORE0_S_AXIS_TSTRB;
                mux_user           = CORE0_S_AXIS_TUSER;
                mux_last           = CORE0_S_AXIS_TLAST;
                rdy_vec[SRC_CORE0] = slice_space;
            end
            ST_GNT_CORE1: begin
                mux_valid          = CORE1_S_AXIS_TVALID;
                mux_data           = CORE1_S_AXIS_TDATA;
                mux_strb           = CORE1_S_AXIS_TSTRB;
                mux_user           = CORE1_S_AXIS_TUSER;
                mux_last           = CORE1_S_AXIS_TLAST;
                rdy_vec[SRC_CORE1] = slice_space;
            end
            default: ;
        endcase
        // A beat offered during reset would be dropped, so never signal acceptance then
        if (ARESET) begin
            rdy_vec = '0;
        end
    end

    assign beat_accept         = mux_valid && (|rdy_vec);
    assign ICAP_S_AXIS_TREADY  = rdy_vec[SRC_ICAP];
    assign CORE0_S_AXIS_TREADY = rdy_vec[SRC_CORE0];
    assign CORE1_S_AXIS_TREADY = rdy_vec[SRC_CORE1];

    // Grant FSM: ICAP first, cores alternate; grant held until the TLAST beat is accepted
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            last_core <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_icap) begin
                        state <= ST_GNT_ICAP;
                    end else if (req_core0 && (!req_core1 || last_core)) begin
                        state     <= ST_GNT_CORE0;
                        last_core <= 1'b0;
                    end else if (req_core1) begin
                        state     <= ST_GNT_CORE1;
                        last_core <= 1'b1;
                    end
                end
                default: begin
                    if (beat_accept && mux_last) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Completed-packet counters, free-running modulo 2^32
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_icap  <= '0;
            cnt_core0 <= '0;
            cnt_core1 <= '0;
        end else if (beat_accept && mux_last) begin
            case (state)
                ST_GNT_ICAP:  cnt_icap  <= cnt_icap + 32'd1;
                ST_GNT_CORE0: cnt_core0 <= cnt_core0 + 32'd1;
                ST_GNT_CORE1: cnt_core1 <= cnt_core1 + 32'd1;
                default: ;
            endcase
        end
    end

    assign grant_state   = state;
    assign pkt_cnt_icap  = cnt_icap;
    assign pkt_cnt_core0 = cnt_core0;
    assign pkt_cnt_core1 = cnt_core1;

    pr_hrav_axis_reg_slice #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (C_USER_WIDTH)
    ) u_out_slice (
        .clk       (ACLK),
        .rst       (ARESET),
        .load      (beat_accept),
        .load_data (mux_data),
        .load_strb (mux_strb),
        .load_user (mux_user),
        .load_last (mux_last),
        .space     (slice_space),
        .data      (M_AXIS_TDATA),
        .strb      (M_AXIS_TSTRB),
        .user      (M_AXIS_TUSER),
        .last      (M_AXIS_TLAST),
        .valid     (M_AXIS_TVALID),
        .ready     (M_AXIS_TREADY)
    );

endmodule

// File: tb/tb_pr_hrav_collector_arbiter.sv
// Bench for the collector arbiter: queue-driven sources, output monitor, packet-order reference model.
// Sources present their queue head continuously; expected order is derived from the arbitration rules.
// Backpressure is applied from the tests through M_AXIS_TREADY.
module tb_pr_hrav_collector_arbiter;

    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        int src;
        int cyc;
    } acc_t;

    localparam beat_t BEAT_ZERO = '0;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          core_0_enb = 1'b1;
    logic          core_1_enb = 1'b1;
    logic [DW-1:0] M_AXIS_TDATA;
    logic [SW-1:0] M_AXIS_TSTRB;
    logic [UW-1:0] M_AXIS_TUSER;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY = 1'b1;
    logic [DW-1:0] CORE0_S_AXIS_TDATA, CORE1_S_AXIS_TDATA, ICAP_S_AXIS_TDATA;
    logic [SW-1:0] CORE0_S_AXIS_TSTRB, CORE1_S_AXIS_TSTRB, ICAP_S_AXIS_TSTRB;
    logic [UW-1:0] CORE0_S_AXIS_TUSER, CORE1_S_AXIS_TUSER, ICAP_S_AXIS_TUSER;
    logic          CORE0_S_AXIS_TLAST, CORE1_S_AXIS_TLAST, ICAP_S_AXIS_TLAST;
    logic          CORE0_S_AXIS_TVALID, CORE1_S_AXIS_TVALID, ICAP_S_AXIS_TVALID;
    logic          CORE0_S_AXIS_TREADY, CORE1_S_AXIS_TREADY, ICAP_S_AXIS_TREADY;
    logic [1:0]    grant_state;
    logic [31:0]   pkt_cnt_core0, pkt_cnt_core1, pkt_cnt_icap;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    beat_t q_icap[$];
    beat_t q_c0[$];
    beat_t q_c1[$];
    beat_t outq[$];
    int    out_cyc[$];
    acc_t  acc_log[$];
    beat_t expq[$];
    int    exp_pk[3];

    pr_hrav_collector_arbiter dut (
        .ACLK                (ACLK),
        .ARESET              (ARESET),
        .core_0_enb          (core_0_enb),
        .core_1_enb          (core_1_enb),
        .M_AXIS_TDATA        (M_AXIS_TDATA),
        .M_AXIS_TSTRB        (M_AXIS_TSTRB),
        .M_AXIS_TUSER        (M_AXIS_TUSER),
        .M_AXIS_TLAST        (M_AXIS_TLAST),
        .M_AXIS_TVALID       (M_AXIS_TVALID),
        .M_AXIS_TREADY       (M_AXIS_TREADY),
        .CORE0_S_AXIS_TDATA  (CORE0_S_AXIS_TDATA),
        .CORE0_S_AXIS_TSTRB  (CORE0_S_AXIS_TSTRB),
        .CORE0_S_AXIS_TUSER  (CORE0_S_AXIS_TUSER),
        .CORE0_S_AXIS_TLAST  (CORE0_S_AXIS_TLAST),
        .CORE0_S_AXIS_TVALID (CORE0_S_AXIS_TVALID),
        .CORE0_S_AXIS_TREADY (CORE0_S_AXIS_TREADY),
        .CORE1_S_AXIS_TDATA  (CORE1_S_AXIS_TDATA),
        .CORE1_S_AXIS_TSTRB  (CORE1_S_AXIS_TSTRB),
        .CORE1_S_AXIS_TUSER  (CORE1_S_AXIS_TUSER),
        .CORE1_S_AXIS_TLAST  (CORE1_S_AXIS_TLAST),
        .CORE1_S_AXIS_TVALID (CORE1_S_AXIS_TVALID),
        .CORE1_S_AXIS_TREADY (CORE1_S_AXIS_TREADY),
        .ICAP_S_AXIS_TDATA   (ICAP_S_AXIS_TDATA),
        .ICAP_S_AXIS_TSTRB   (ICAP_S_AXIS_TSTRB),
        .ICAP_S_AXIS_TUSER   (ICAP_S_AXIS_TUSER),
        .ICAP_S_AXIS_TLAST   (ICAP_S_AXIS_TLAST),
        .ICAP_S_AXIS_TVALID  (ICAP_S_AXIS_TVALID),
        .ICAP_S_AXIS_TREADY  (ICAP_S_AXIS_TREADY),
        .grant_state         (grant_state),
        .pkt_cnt_core0       (pkt_cnt_core0),
        .pkt_cnt_core1       (pkt_cnt_core1),
        .pkt_cnt_icap        (pkt_cnt_icap)
    );

    initial forever #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Present each queue head on its source port
    task automatic drive_sources();
        beat_t hi, h0, h1;
        hi = (q_icap.size() != 0) ? q_icap[0] : BEAT_ZERO;
        h0 = (q_c0.size() != 0) ? q_c0[0] : BEAT_ZERO;
        h1 = (q_c1.size() != 0) ? q_c1[0] : BEAT_ZERO;
        {ICAP_S_AXIS_TDATA, ICAP_S_AXIS_TSTRB, ICAP_S_AXIS_TUSER, ICAP_S_AXIS_TLAST} = hi;
        {CORE0_S_AXIS_TDATA, CORE0_S_AXIS_TSTRB, CORE0_S_AXIS_TUSER, CORE0_S_AXIS_TLAST} = h0;
        {CORE1_S_AXIS_TDATA, CORE1_S_AXIS_TSTRB, CORE1_S_AXIS_TUSER, CORE1_S_AXIS_TLAST} = h1;
        ICAP_S_AXIS_TVALID  = (q_icap.size() != 0);
        CORE0_S_AXIS_TVALID = (q_c0.size() != 0);
        CORE1_S_AXIS_TVALID = (q_c1.size() != 0);
    endtask

    // Source drivers and master monitor: handshakes sampled mid-cycle, queues advanced after the edge
    initial begin : driver
        bit hs_i, hs_0, hs_1, rst_seen;
        drive_sources();
        forever begin
            @(negedge ACLK);
            hs_i = ICAP_S_AXIS_TVALID && ICAP_S_AXIS_TREADY;
            hs_0 = CORE0_S_AXIS_TVALID && CORE0_S_AXIS_TREADY;
            hs_1 = CORE1_S_AXIS_TVALID && CORE1_S_AXIS_TREADY;
            rst_seen = ARESET;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                outq.push_back({M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST});
                out_cyc.push_back(cyc);
            end
            @(posedge ACLK);
            #1;
            if (rst_seen) begin
                q_icap.delete();
                q_c0.delete();
                q_c1.delete();
            end else begin
                if (hs_i) begin void'(q_icap.pop_front()); acc_log.push_back('{0, cyc}); end
                if (hs_0) begin void'(q_c0.pop_front());   acc_log.push_back('{1, cyc}); end
                if (hs_1) begin void'(q_c1.pop_front());   acc_log.push_back('{2, cyc}); end
            end
            drive_sources();
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        core_0_enb = 1'b1;
        core_1_enb = 1'b1;
        M_AXIS_TREADY = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
        outq.delete();
        out_cyc.delete();
        acc_log.delete();
    endtask

    // Packet beats tagged with source id and beat index in the top data bytes
    task automatic push_pkt(input int src, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
            b.data[DW-1 -: 8] = 8'(src);
            b.data[DW-9 -: 8] = 8'(i);
            b.strb = $urandom;
            b.user = {$urandom, $urandom, $urandom, $urandom};
            b.last = (i == len - 1);
            case (src)
                0: q_icap.push_back(b);
                1: q_c0.push_back(b);
                default: q_c1.push_back(b);
            endcase
        end
    endtask

    // Reference: all queued packets are requesting together; whole packets move in arbitration order
    task automatic build_expected(input bit en0, input bit en1);
        beat_t qs[3][$];
        bit    core1_was_last;
        int    pick;
        beat_t b;
        qs[0] = q_icap;
        qs[1] = en0 ? q_c0 : qs[1];
        qs[2] = en1 ? q_c1 : qs[2];
        core1_was_last = 1'b1;
        expq.delete();
        exp_pk = '{0, 0, 0};
        while (qs[0].size() + qs[1].size() + qs[2].size() != 0) begin
            if (qs[0].size() != 0) pick = 0;
            else if (qs[1].size() == 0) pick = 2;
            else if (qs[2].size() == 0) pick = 1;
            else pick = core1_was_last ? 1 : 2;
            if (pick != 0) core1_was_last = (pick == 2);
            exp_pk[pick]++;
            do begin
                b = qs[pick].pop_front();
                expq.push_back(b);
            end while (!b.last && qs[pick].size() != 0);
        end
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int k = 0;
        while (outq.size() < n && k < budget) begin
            tick();
            k++;
        end
        total++;
        if (outq.size() < n) begin
            bad++;
            $display("FAIL %s_timeout got=%0d beats want=%0d", name, outq.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] obs[12];
        string nm[12];
        do_reset();
        obs = '{M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST, grant_state,
                ICAP_S_AXIS_TREADY, CORE0_S_AXIS_TREADY, CORE1_S_AXIS_TREADY,
                pkt_cnt_icap, pkt_cnt_core0, pkt_cnt_core1};
        nm = '{"tvalid", "tdata", "tstrb", "tuser", "tlast", "grant_state",
               "icap_tready", "core0_tready", "core1_tready", "cnt_icap", "cnt_core0", "cnt_core1"};
        for (int i = 0; i < 12; i++) begin
            total++;
            if (obs[i] !== '0) begin
                bad++;
                $display("FAIL reset_%s got=%h want=0", nm[i], obs[i]);
            end
        end
    endtask

    task automatic test_icap_priority();
        int last_icap = -1, first_c0 = -1;
        do_reset();
        push_pkt(1, 4);
        push_pkt(0, 4);
        build_expected(1, 1);
        tick();
        total++;
        if (grant_state !== 2'd0 || ICAP_S_AXIS_TREADY !== 1'b0) begin
            bad++;
            $display("FAIL prio_arb_cycle got gs=%0d rdy=%b want gs=0 rdy=0", grant_state, ICAP_S_AXIS_TREADY);
        end
        tick();
        total++;
        if (grant_state !== 2'd1 || ICAP_S_AXIS_TREADY !== 1'b1 || CORE0_S_AXIS_TREADY !== 1'b0) begin
            bad++;
            $display("FAIL prio_grant got gs=%0d icap_rdy=%b c0_rdy=%b want gs=1 icap_rdy=1 c0_rdy=0",
                     grant_state, ICAP_S_AXIS_TREADY, CORE0_S_AXIS_TREADY);
        end
        wait_out(8, 60, "prio");
        tick();
        total++;
        if (outq.size() !== expq.size()) begin
            bad++;
            $display("FAIL prio_len got=%0d want=%0d", outq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== expq[i]) begin
                bad++;
                $display("FAIL prio_beat%0d got=%h want=%h", i, outq[i], expq[i]);
            end
        end
        foreach (acc_log[i]) begin
            if (acc_log[i].src == 0) last_icap = acc_log[i].cyc;
            if (acc_log[i].src == 1 && first_c0 < 0) first_c0 = acc_log[i].cyc;
        end
        total++;
        if (first_c0 - last_icap != 2) begin
            bad++;
            $display("FAIL prio_bubble got=%0d cycles want=2", first_c0 - last_icap);
        end
        total++;
        if (out_cyc.size() >= 8 && (out_cyc[3] - out_cyc[0] != 3 || out_cyc[4] - out_cyc[3] != 2)) begin
            bad++;
            $display("FAIL prio_timing got=%0d,%0d want=3,2", out_cyc[3] - out_cyc[0], out_cyc[4] - out_cyc[3]);
        end
        total++;
        if (pkt_cnt_icap !== 32'd1 || pkt_cnt_core0 !== 32'd1) begin
            bad++;
            $display("FAIL prio_counts got icap=%0d core0=%0d want 1,1", pkt_cnt_icap, pkt_cnt_core0);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] src_b;
        logic [7:0] want_src[4];
        want_src = '{8'd1, 8'd2, 8'd1, 8'd2};
        do_reset();
        push_pkt(1, 2); push_pkt(2, 2); push_pkt(1, 2); push_pkt(2, 2);
        build_expected(1, 1);
        wait_out(8, 60, "rr");
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== expq[i]) begin
                bad++;
                $display("FAIL rr_beat%0d got=%h want=%h", i, outq[i], expq[i]);
            end
        end
        for (int p = 0; p < 4 && 2 * p < outq.size(); p++) begin
            src_b = outq[2*p].data[DW-1 -: 8];
            total++;
            if (src_b !== want_src[p]) begin
                bad++;
                $display("FAIL rr_order pkt%0d got src=%0d want=%0d", p, src_b, want_src[p]);
            end
            if (p > 0) begin
                total++;
                if (out_cyc[2*p] - out_cyc[2*p-2] != 3) begin
                    bad++;
                    $display("FAIL rr_period pkt%0d got=%0d want=3", p, out_cyc[2*p] - out_cyc[2*p-2]);
                end
            end
        end
        total++;
        if (pkt_cnt_core0 !== 32'd2 || pkt_cnt_core1 !== 32'd2) begin
            bad++;
            $display("FAIL rr_counts got c0=%0d c1=%0d want 2,2", pkt_cnt_core0, pkt_cnt_core1);
        end
    endtask

    task automatic test_enable();
        bit c1_rdy_seen = 1'b0;
        int k = 0;
        do_reset();
        core_1_enb = 1'b0;
        push_pkt(2, 2);
        push_pkt(1, 1);
        build_expected(1, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (CORE1_S_AXIS_TREADY) c1_rdy_seen = 1'b1;
        end
        total++;
        if (c1_rdy_seen || outq.size() !== 1) begin
            bad++;
            $display("FAIL enb_block got c1_rdy_seen=%b beats=%0d want 0,1", c1_rdy_seen, outq.size());
        end
        if (outq.size() == 1) begin
            total++;
            if (outq[0] !== expq[0]) begin
                bad++;
                $display("FAIL enb_c0_beat got=%h want=%h", outq[0], expq[0]);
            end
        end
        do_reset();
        push_pkt(2, 5);
        build_expected(1, 1);
        while (acc_log.size() == 0 && k < 20) begin tick(); k++; end
        core_1_enb = 1'b0;
        wait_out(5, 40, "enb_drop");
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== expq[i]) begin
                bad++;
                $display("FAIL enb_drop_beat%0d got=%h want=%h", i, outq[i], expq[i]);
            end
        end
        total++;
        if (pkt_cnt_core1 !== 32'd1) begin
            bad++;
            $display("FAIL enb_drop_count got=%0d want=1", pkt_cnt_core1);
        end
    endtask

    task automatic test_backpressure();
        bit pat[4];
        bit prev_stall = 1'b0;
        logic [DW-1:0] prev_dat = '0;
        int k = 0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        push_pkt(1, 8);
        build_expected(1, 1);
        while (outq.size() < 8 && k < 80) begin
            tick();
            if (prev_stall) begin
                total++;
                if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== prev_dat) begin
                    bad++;
                    $display("FAIL bp_hold got vld=%b dat=%h want vld=1 dat=%h", M_AXIS_TVALID, M_AXIS_TDATA, prev_dat);
                end
            end
            M_AXIS_TREADY = pat[k % 4];
            #1;
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_dat = M_AXIS_TDATA;
            if (prev_stall) begin
                total++;
                if (CORE0_S_AXIS_TREADY !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_tready got=%b want=0", CORE0_S_AXIS_TREADY);
                end
            end
            k++;
        end
        M_AXIS_TREADY = 1'b1;
        total++;
        if (outq.size() !== 8) begin
            bad++;
            $display("FAIL bp_len got=%0d want=8", outq.size());
        end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== expq[i]) begin
                bad++;
                $display("FAIL bp_beat%0d got=%h want=%h", i, outq[i], expq[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        do_reset();
        push_pkt(1, 6);
        while (acc_log.size() < 3 && k < 30) begin tick(); k++; end
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        total++;
        if (M_AXIS_TVALID !== 1'b0 || grant_state !== 2'd0 || pkt_cnt_core0 !== 32'd0 || CORE0_S_AXIS_TREADY !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_state got vld=%b gs=%0d cnt=%0d rdy=%b want 0,0,0,0",
                     M_AXIS_TVALID, grant_state, pkt_cnt_core0, CORE0_S_AXIS_TREADY);
        end
        total++;
        if (acc_log.size() !== 3 || outq.size() !== 3) begin
            bad++;
            $display("FAIL rstmid_beats got acc=%0d out=%0d want 3,3", acc_log.size(), outq.size());
        end
        outq.delete();
        out_cyc.delete();
        push_pkt(2, 2);
        push_pkt(1, 2);
        build_expected(1, 1);
        wait_out(4, 40, "rstmid");
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== expq[i]) begin
                bad++;
                $display("FAIL rstmid_beat%0d got=%h want=%h", i, outq[i], expq[i]);
            end
        end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        force dut.cnt_icap = 32'hFFFF_FFFF;
        tick();
        release dut.cnt_icap;
        tick();
        total++;
        if (pkt_cnt_icap !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL wrap_preload got=%h want=ffffffff", pkt_cnt_icap);
        end
        push_pkt(0, 2);
        build_expected(1, 1);
        wait_out(2, 30, "wrap");
        tick();
        total++;
        if (pkt_cnt_icap !== 32'h0) begin
            bad++;
            $display("FAIL wrap_count got=%h want=0", pkt_cnt_icap);
        end
    endtask

    task automatic test_random();
        int n0, n1, ni, k;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            ni = $urandom_range(0, 2);
            n0 = $urandom_range(1, 3);
            n1 = $urandom_range(0, 3);
            for (int p = 0; p < n0; p++) push_pkt(1, $urandom_range(1, 5));
            for (int p = 0; p < n1; p++) push_pkt(2, $urandom_range(1, 5));
            for (int p = 0; p < ni; p++) push_pkt(0, $urandom_range(1, 5));
            build_expected(1, 1);
            k = 0;
            while (outq.size() < expq.size() && k < 600) begin
                tick();
                M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
                k++;
            end
            M_AXIS_TREADY = 1'b1;
            tick();
            tick();
            total++;
            if (outq.size() !== expq.size()) begin
                bad++;
                $display("FAIL rand%0d_len got=%0d want=%0d", r, outq.size(), expq.size());
            end
            for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
                total++;
                if (outq[i] !== expq[i]) begin
                    bad++;
                    $display("FAIL rand%0d_beat%0d got=%h want=%h", r, i, outq[i], expq[i]);
                end
            end
            total++;
            if (pkt_cnt_icap !== 32'(exp_pk[0]) || pkt_cnt_core0 !== 32'(exp_pk[1]) || pkt_cnt_core1 !== 32'(exp_pk[2])) begin
                bad++;
                $display("FAIL rand%0d_counts got %0d/%0d/%0d want %0d/%0d/%0d", r,
                         pkt_cnt_icap, pkt_cnt_core0, pkt_cnt_core1, exp_pk[0], exp_pk[1], exp_pk[2]);
            end
        end
    endtask

    initial begin : main
        test_reset();
        test_icap_priority();
        test_round_robin();
        test_enable();
        test_backpressure();
        test_reset_mid();
        test_cnt_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pr_hrav_collector_arbiter.md
# pr_hrav_collector_arbiter

Packet-granular arbiter that merges the CORE0, CORE1 and ICAP AXI4-Stream result streams onto the single collector master stream toward the DMA/output path. ICAP traffic has strict priority; the two hardware-RAV cores share the remaining bandwidth round-robin, gated by their enables. A grant is held from first beat to the TLAST beat, so packets never interleave. The master side is a one-beat registered slice, and per-source packet counters are exposed for debug.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, master TDATA width; must equal C_S_AXIS_DATA_WIDTH.
- C_S_AXIS_DATA_WIDTH, 256, slave TDATA width.
- C_USER_WIDTH, 128, TUSER width on all ports.
- ACLK  in  1  single clock for all logic.
- ARESET  in  1  synchronous, active-high reset, sampled on the ACLK rising edge.
- core_0_enb, core_1_enb  in  1  core eligibility for new grants.
- M_AXIS_TDATA/TSTRB/TUSER/TLAST/TVALID  out  256/32/128/1/1  merged stream; TSTRB width = DATA/8.
- M_AXIS_TREADY  in  1  downstream ready.
- {CORE0,CORE1,ICAP}_S_AXIS_TDATA/TSTRB/TUSER/TLAST/TVALID  in  256/32/128/1/1  source streams.
- {CORE0,CORE1,ICAP}_S_AXIS_TREADY  out  1  per-source ready.
- grant_state  out  2  0 IDLE, 1 ICAP, 2 CORE0, 3 CORE1.
- pkt_cnt_core0, pkt_cnt_core1, pkt_cnt_icap  out  32  completed-packet counters.

## Operation
- FSM states: IDLE, GNT_ICAP, GNT_CORE0, GNT_CORE1.
- In IDLE, eligible requesters are ICAP_S_AXIS_TVALID, CORE0_S_AXIS_TVALID&core_0_enb and CORE1_S_AXIS_TVALID&core_1_enb. ICAP wins whenever it is eligible.
- Otherwise the core not equal to last_core wins. If only one core is eligible, that core wins. With no request the FSM stays in IDLE.
- last_core updates on entry to GNT_CORE0/1. Reset value is 1, so CORE0 is first.
- In GNT_x: x_S_AXIS_TREADY = !m_valid_r | M_AXIS_TREADY. All other TREADYs are 0, and all TREADYs are 0 in IDLE.
- A source beat is accepted on x_TVALID & x_TREADY. On acceptance the beat is loaded into the output register (TDATA/TSTRB/TUSER/TLAST) and m_valid_r is set to 1.
- When M_AXIS_TREADY is high and no new beat loads, m_valid_r is cleared.
- An accepted beat with TLAST=1 returns the FSM to IDLE and increments pkt_cnt_x (wraps at 2^32).
- Deasserting core_N_enb mid-packet does not abort the packet; it only blocks new grants.
- A source deasserting TVALID mid-packet holds the grant indefinitely. There is no timeout.
- Reset values: FSM IDLE, M_AXIS_TVALID 0, M_AXIS_TDATA/TSTRB/TUSER/TLAST 0, all S TREADY 0, counters 0, grant_state 0. Reset mid-packet drops the in-flight beat and the partial packet.

## Timing
- Arbitration takes 1 cycle: a request seen in IDLE at cycle n gives TREADY at cycle n+1.
- Source-to-master latency is 1 cycle: a beat accepted at edge n appears on M_AXIS at n+1.
- Throughput is 1 beat/cycle within a packet while M_AXIS_TREADY=1.
- There is 1 IDLE bubble cycle between packets.
- Backpressure: with M_AXIS_TREADY=0 and m_valid_r=1, the granted TREADY is 0 in the same cycle (combinational from M_AXIS_TREADY). The output holds stable while TVALID=1 and TREADY=0.
- Simultaneous TLAST acceptance and new requests: the FSM goes to IDLE first, and the new arbitration happens in the following cycle.

## Structure
- Shared package pr_hrav_pkg holds the grant_state encoding constants (GS_IDLE/GS_ICAP/GS_CORE0/GS_CORE1), the source-index constants, and the width check (DATA/8 for STRB).
- Sub-module pr_hrav_axis_reg_slice: the one-beat output register (data, valid, ready logic), parameterised by data/user width.
- The arbiter FSM, the mux and the counters stay in the top module.

## Test plan
- ICAP and CORE0 both send 4-beat packets, both valid at cycle 0 -> ICAP beats 1-4 are output first, CORE0 TREADY=0 until ICAP TLAST, then the CORE0 packet follows; pkt_cnt_icap=1, pkt_cnt_core0=1.
- CORE0 and CORE1 continuously valid with 2-beat packets, both enabled -> grant order CORE0, CORE1, CORE0, CORE1; with M_AXIS_TREADY=1 each packet takes 3 cycles including the bubble.
- core_1_enb=0 with CORE1 valid -> CORE1 TREADY stays 0 and no CORE1 data appears. core_1_enb dropped mid-CORE1-packet -> the packet completes intact.
- M_AXIS_TREADY toggling 1,0,0,1 during an 8-beat CORE0 packet -> all 8 beats arrive in order, no duplicate or lost beat, and TDATA stays stable while stalled.
- ARESET asserted for 1 cycle at beat 3 of 6 -> next cycle TVALID=0, counters 0, FSM IDLE; a new CORE0 packet is then granted with the round-robin pointer reset.
- pkt_cnt_icap forced to 0xFFFFFFFF, then one ICAP packet completes -> counter wraps to 0.
